// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared types and helpers for the vedic multiplier/accumulator family
//
// Purpose : FSM state encoding for vedic_prod_accum and a power-of-two check
//           used by the parameter checks of vedic_prod_accum and vedic_nbit_mul.
// Ports   : none (package).
package vedic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cla_nbit.sv
// rtl/cla_nbit.sv - parallel-prefix carry-lookahead adder of configurable width
//
// Purpose : s = a + b + cin with carry-out, carries resolved by a
//           Kogge-Stone generate/propagate prefix tree.
// Ports   : a     in  WIDTH  addend
//           b     in  WIDTH  addend
//           cin   in  1      carry in
//           s     out WIDTH  sum (mod 2^WIDTH)
//           cout  out 1      carry out of the top bit
module cla_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_pre_g;
  logic [WIDTH-1:0] w_pre_p;
  logic [WIDTH-1:0] w_nxt_g;
  logic [WIDTH-1:0] w_nxt_p;
  logic [WIDTH-1:0] w_carry;

  always_comb begin
    w_p0    = a ^ b;
    // cin is folded into bit 0's generate so the prefix tree needs no
    // separate carry-in column.
    w_pre_g = (a & b) | WIDTH'(cin & w_p0[0]);
    w_pre_p = w_p0;
    w_nxt_g = w_pre_g;
    w_nxt_p = w_pre_p;
    for (int l = 0; l < LEVELS; l++) begin
      w_nxt_g = w_pre_g;
      w_nxt_p = w_pre_p;
      for (int i = (1 << l); i < WIDTH; i++) begin
        w_nxt_g[i] = w_pre_g[i] | (w_pre_p[i] & w_pre_g[i - (1 << l)]);
        w_nxt_p[i] = w_pre_p[i] & w_pre_p[i - (1 << l)];
      end
      w_pre_g = w_nxt_g;
      w_pre_p = w_nxt_p;
    end
    // w_carry[i] is the carry out of bit i.
    w_carry = w_pre_g;

    s    = '0;
    s[0] = w_p0[0] ^ cin;
    for (int i = 1; i < WIDTH; i++) begin
      s[i] = w_p0[i] ^ w_carry[i-1];
    end
    cout = w_carry[WIDTH-1];
  end

endmodule

// File: rtl/vedic_prod_accum.sv
// rtl/vedic_prod_accum.sv - run-based accumulator of vedic multiplier products
//
// Purpose : On start, accumulates exactly len products from the upstream
//           multiplier (valid/ready handshake), then presents the sum, a
//           sticky carry-out flag and the accepted count until taken.
// Ports   : clk        in  1          clock, rising edge
//           rst_n      in  1          asynchronous active-low reset
//           start      in  1          begin a run (honoured in IDLE only)
//           len        in  CNT_WIDTH  number of products in the run
//           busy       out 1          not IDLE
//           in_valid   in  1          product valid
//           in_ready   out 1          product accepted when valid
//           in_prod    in  2*WIDTH    product
//           out_valid  out 1          result valid
//           out_ready  in  1          result taken when valid
//           out_acc    out ACC_WIDTH  accumulated sum
//           out_ovf    out 1          sticky accumulator carry-out
//           out_count  out CNT_WIDTH  products accepted in the run
module vedic_prod_accum
  import vedic_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int ACC_WIDTH = 2*WIDTH+8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   in_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf,
  output logic [CNT_WIDTH-1:0] out_count
);

  if (!is_pow2(WIDTH) || (WIDTH < 2)) begin : g_bad_width
    $fatal(1, "vedic_prod_accum: WIDTH must be a power of two and >= 2");
  end

  if (ACC_WIDTH < 2*WIDTH) begin : g_bad_acc_width
    $fatal(1, "vedic_prod_accum: ACC_WIDTH must be >= 2*WIDTH");
  end

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_ovf;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   r_remaining;

  logic                   w_accept;
  logic [ACC_WIDTH-1:0]   w_sum;
  logic                   w_cout;

  cla_nbit #(
    .WIDTH (ACC_WIDTH)
  ) u_acc_add (
    .a    (r_acc),
    .b    (ACC_WIDTH'(in_prod)),
    .cin  (1'b0),
    .s    (w_sum),
    .cout (w_cout)
  );

  // in_ready depends on state only, so accept is a plain AND with in_valid.
  assign w_accept = (r_state == ST_ACCUM) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (len == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid && (r_remaining == CNT_WIDTH'(1))) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        // Going to IDLE (not straight into a new run) guarantees at least one
        // idle cycle between runs even if start is high here.
        if (out_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_remaining <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_remaining <= len;
    end else if (w_accept) begin
      r_acc       <= w_sum;
      r_ovf       <= r_ovf | w_cout;
      r_count     <= r_count + CNT_WIDTH'(1);
      r_remaining <= r_remaining - CNT_WIDTH'(1);
    end
  end

  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;
  assign out_count = r_count;

endmodule

// File: tb/tb_vedic_prod_accum.sv
// tb/tb_vedic_prod_accum.sv - self-checking bench for vedic_prod_accum
module tb_vedic_prod_accum;

  localparam int W  = 4;
  localparam int AW = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] in_prod;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_acc;
  logic          out_ovf;
  logic [CW-1:0] out_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vedic_prod_accum #(
    .WIDTH     (W),
    .ACC_WIDTH (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One complete run. mode: 0 continuous valid, 1 alternating, 2 random.
  // hold: cycles out_ready stays low in DONE; poke: pulse start in DONE and
  // together with out_ready.
  task automatic run(input string tag, input int ln, input int prods[$],
                     input int mode, input int hold, input bit poke);
    int  idx = 0;
    int  cyc = 0;
    bit  v;
    int  total = 0;
    int  e_acc;
    int  e_ovf;

    foreach (prods[k]) total += prods[k];
    e_acc = total % (1 << AW);
    e_ovf = (total >= (1 << AW)) ? 1 : 0;

    @(negedge clk);
    start = 1'b1;
    len   = CW'(ln);
    @(negedge clk);
    start = 1'b0;
    len   = '0;

    while (idx < ln && cyc < 200) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else                v = ($urandom_range(0, 1) == 1);
      in_valid = v;
      in_prod  = (2*W)'(prods[idx]);
      if (cyc == 0) begin
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".busy"}, busy, 1);
        check({tag, ".early_valid"}, out_valid, 0);
      end
      @(negedge clk);
      if (v) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_prod  = '0;
    if (idx < ln) check({tag, ".timeout"}, idx, ln);

    check({tag, ".out_valid"}, out_valid, 1);
    check({tag, ".in_ready_done"}, in_ready, 0);
    check({tag, ".acc"}, out_acc, e_acc);
    check({tag, ".ovf"}, out_ovf, e_ovf);
    check({tag, ".count"}, out_count, ln);

    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (poke && h == 1) begin
        start = 1'b1;
        len   = CW'(7);
      end else begin
        start = 1'b0;
        len   = '0;
      end
      @(negedge clk);
      check({tag, ".hold_valid"}, out_valid, 1);
      check({tag, ".hold_acc"}, out_acc, e_acc);
      check({tag, ".hold_count"}, out_count, ln);
    end
    start = 1'b0;

    out_ready = 1'b1;
    start     = poke;
    len       = CW'(3);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    len       = '0;
    check({tag, ".idle_busy"}, busy, 0);
    check({tag, ".idle_valid"}, out_valid, 0);
    if (poke) begin
      @(negedge clk);
      check({tag, ".start_ignored"}, busy, 0);
    end
  endtask

  initial begin
    int q[$];
    int ln;

    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_prod   = '0;
    out_ready = 1'b0;

    #12;
    check("rst.busy", busy, 0);
    check("rst.in_ready", in_ready, 0);
    check("rst.out_valid", out_valid, 0);
    check("rst.acc", out_acc, 0);
    check("rst.ovf", out_ovf, 0);
    check("rst.count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    q = {25, 225, 0};
    run("len3", 3, q, 0, 0, 1'b0);

    q = {225, 225, 225, 225, 225};
    run("len5_ovf", 5, q, 0, 1, 1'b0);

    q.delete();
    run("len0", 0, q, 0, 0, 1'b0);

    q = {1, 2, 3, 4};
    run("alt4", 4, q, 1, 5, 1'b1);

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    len   = CW'(4);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_prod  = 8'd10;
    @(negedge clk);
    in_prod  = 8'd20;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid.count_before", out_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid.busy", busy, 0);
    check("mid.in_ready", in_ready, 0);
    check("mid.out_valid", out_valid, 0);
    check("mid.acc", out_acc, 0);
    check("mid.count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    q = {7};
    run("after_rst", 1, q, 0, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      ln = $urandom_range(1, 15);
      q.delete();
      for (int k = 0; k < ln; k++) q.push_back($urandom_range(0, 255));
      run($sformatf("rand%0d", r), ln, q, 2, $urandom_range(0, 3), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
